// File: rtl/sd_stream_wr.sv
// sd_stream_wr: buffers a 16-bit word stream in a circular FIFO and
// feeds an SD write controller one 512-byte sector at a time.
module sd_stream_wr #(
    parameter logic [31:0] START_ADDR = 32'd2000,
    parameter int          SEC_WORDS  = 256,
    parameter int          FIFO_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        din_valid,
    input  logic [15:0] din,
    output logic        din_ready,
    input  logic        flush,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    output logic [31:0] sec_cnt,
    output logic        overflow,
    output logic        done
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   SEC_C    = (AW+1)'(SEC_WORDS);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [8:0]    SEC_W    = 9'(SEC_WORDS);

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, START, WAIT_BUSY, XFER, WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [8:0]    wcnt_q, wcnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sec_cnt_q, sec_cnt_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          pend_q, pend_d;
    logic          push, pop, serve, xfer_act, empty, fin;

    assign empty     = (count_q == '0);
    assign din_ready = (count_q != DEPTH_C);
    assign push      = din_valid && din_ready;
    assign xfer_act  = (state_q == XFER) && (wcnt_q < SEC_W);
    // An empty FIFO with a flush pending still serves: zero padding.
    assign serve     = xfer_act && wr_req && (!empty || pend_q);
    assign pop       = serve && !empty;
    assign wr_data   = (xfer_act && !empty) ? mem_q[rd_ptr_q] : 16'h0000;

    assign wr_start_en = start_q;
    assign wr_sec_addr = addr_q;
    assign sec_cnt     = sec_cnt_q;
    assign overflow    = ovf_q;
    assign done        = done_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        sec_cnt_d = sec_cnt_q;
        start_d   = 1'b0;
        fin       = 1'b0;
        if (push)
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
        unique case (state_q)
            IDLE: begin
                if (sd_init_done)
                    state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (sd_init_done &&
                    (count_q >= SEC_C || (pend_q && !empty))) begin
                    state_d = START;
                    start_d = 1'b1;
                end else if (pend_q && empty) begin
                    fin = 1'b1;
                end
            end
            START: begin
                wcnt_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wr_busy)
                    state_d = XFER;
            end
            XFER: begin
                if (serve) begin
                    wcnt_d = wcnt_q + 9'd1;
                    if (wcnt_q == SEC_W - 9'd1)
                        state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!wr_busy) begin
                    state_d   = WAIT_DATA;
                    addr_d    = addr_q + 32'd1;
                    sec_cnt_d = sec_cnt_q + 32'd1;
                    fin       = pend_q && empty;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = fin;
        pend_d = (pend_q && !fin) || flush;
        ovf_d  = ovf_q || (din_valid && !din_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wcnt_q    <= '0;
            addr_q    <= START_ADDR;
            sec_cnt_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            sec_cnt_q <= sec_cnt_d;
            start_q   <= start_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: tb/tb_sd_stream_wr.sv
// tb_sd_stream_wr: directed bench for sd_stream_wr with a small SD
// write-controller model driving wr_busy and wr_req.
module tb_sd_stream_wr;

    logic        clk = 1'b0;
    logic        rst_n, sd_init_done, din_valid, flush, wr_busy, wr_req;
    logic [15:0] din;
    logic        din_ready, wr_start_en, overflow, done;
    logic [31:0] wr_sec_addr, sec_cnt;
    logic [15:0] wr_data;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_start = 0;
    int          n_done = 0;
    logic [15:0] cap [256];
    logic [31:0] cap_addr;
    bit          ok, ok_d;
    int          s0, d0, lat;

    always #5 clk = ~clk;

    sd_stream_wr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .din_valid    (din_valid),
        .din          (din),
        .din_ready    (din_ready),
        .flush        (flush),
        .wr_busy      (wr_busy),
        .wr_req       (wr_req),
        .wr_start_en  (wr_start_en),
        .wr_sec_addr  (wr_sec_addr),
        .wr_data      (wr_data),
        .sec_cnt      (sec_cnt),
        .overflow     (overflow),
        .done         (done)
    );

    always @(posedge clk) begin
        if (wr_start_en === 1'b1) n_start <= n_start + 1;
        if (done === 1'b1) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cap(input string tag, input int base,
                             input int nvalid);
        int          bad;
        logic [15:0] exp;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            exp = (i < nvalid) ? 16'(base + i) : 16'h0000;
            if (cap[i] !== exp) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din       = 16'(base + i);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic sd_wait_start(output bit got);
        int t;
        got = 1'b0;
        t   = 0;
        while (wr_start_en !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (wr_start_en === 1'b1) begin
            got      = 1'b1;
            cap_addr = wr_sec_addr;
            @(negedge clk);
            wr_busy = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic sd_xfer(input int n);
        for (int i = 0; i < n; i++) begin
            wr_req = 1'b1;
            cap[i] = wr_data;
            @(negedge clk);
        end
        wr_req = 1'b0;
    endtask

    task automatic sd_serve(output bit got);
        sd_wait_start(got);
        if (got) begin
            sd_xfer(256);
            wr_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        flush     = 1'b0;
        wr_busy   = 1'b0;
        wr_req    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        sd_init_done = 1'b0;
        din_valid    = 1'b0;
        din          = 16'h0000;
        flush        = 1'b0;
        wr_busy      = 1'b0;
        wr_req       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_en", 32'(wr_start_en), 32'd0);
        check("rst_addr", wr_sec_addr, 32'd2000);
        check("rst_sec_cnt", sec_cnt, 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // one full sector
        sd_init_done = 1'b1;
        s0 = n_start;
        push_words(0, 256);
        sd_serve(ok);
        check("a_start", 32'(ok), 32'd1);
        check("a_addr", cap_addr, 32'd2000);
        check_cap("a_data", 0, 256);
        check("a_sec_cnt", sec_cnt, 32'd1);
        check("a_next_addr", wr_sec_addr, 32'd2001);
        repeat (4) @(negedge clk);
        check("a_one_pulse", 32'(n_start - s0), 32'd1);

        // partial sector flush
        do_reset();
        s0 = n_start;
        d0 = n_done;
        push_words(0, 100);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sd_serve(ok);
        check("b_start", 32'(ok), 32'd1);
        check("b_addr", cap_addr, 32'd2000);
        check_cap("b_data", 0, 100);
        repeat (4) @(negedge clk);
        check("b_done_once", 32'(n_done - d0), 32'd1);
        check("b_sec_cnt", sec_cnt, 32'd1);
        check("b_one_start", 32'(n_start - s0), 32'd1);

        // stalled SD card, overflow
        do_reset();
        s0 = n_start;
        wr_busy = 1'b1;
        for (int i = 0; i < 520; i++) begin
            if (i == 511) check("c_ready_511", 32'(din_ready), 32'd1);
            if (i == 512) check("c_ready_512", 32'(din_ready), 32'd0);
            din_valid = 1'b1;
            din       = 16'(i);
            @(negedge clk);
        end
        din_valid = 1'b0;
        check("c_overflow", 32'(overflow), 32'd1);
        check("c_one_start", 32'(n_start - s0), 32'd1);
        check("c_addr0", wr_sec_addr, 32'd2000);
        sd_xfer(256);
        check_cap("c_data0", 0, 256);
        wr_busy = 1'b0;
        @(negedge clk);
        sd_serve(ok);
        check("c_start2", 32'(ok), 32'd1);
        check("c_addr1", cap_addr, 32'd2001);
        check_cap("c_data1", 256, 256);
        repeat (8) @(negedge clk);
        check("c_sec_cnt", sec_cnt, 32'd2);
        check("c_two_starts", 32'(n_start - s0), 32'd2);
        check("c_ovf_sticky", 32'(overflow), 32'd1);
        check("c_ready_again", 32'(din_ready), 32'd1);

        // reset in the middle of a sector
        push_words(256, 256);
        sd_wait_start(ok);
        check("e_start", 32'(ok), 32'd1);
        check("e_addr", cap_addr, 32'd2002);
        sd_xfer(128);
        rst_n   = 1'b0;
        wr_busy = 1'b0;
        @(negedge clk);
        check("e_rst_start_en", 32'(wr_start_en), 32'd0);
        check("e_rst_addr", wr_sec_addr, 32'd2000);
        check("e_rst_sec_cnt", sec_cnt, 32'd0);
        check("e_rst_wr_data", 32'(wr_data), 32'd0);
        check("e_rst_overflow", 32'(overflow), 32'd0);
        check("e_rst_din_ready", 32'(din_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        push_words(40960, 256);
        sd_serve(ok);
        check("e_start2", 32'(ok), 32'd1);
        check("e_addr2", cap_addr, 32'd2000);
        check_cap("e_data", 40960, 256);
        check("e_sec_cnt", sec_cnt, 32'd1);
        check("e_overflow", 32'(overflow), 32'd0);

        // streaming with simultaneous push and pop
        do_reset();
        fork
            push_words(0, 1024);
            begin
                for (int s = 0; s < 4; s++) begin
                    sd_serve(ok_d);
                    check("d_start", 32'(ok_d), 32'd1);
                    check("d_addr", cap_addr, 32'(2000 + s));
                    check_cap("d_data", 256 * s, 256);
                end
            end
        join
        check("d_sec_cnt", sec_cnt, 32'd4);
        check("d_next_addr", wr_sec_addr, 32'd2004);
        check("d_overflow", 32'(overflow), 32'd0);

        // card not initialised; stray wr_req ignored
        sd_init_done = 1'b0;
        do_reset();
        s0 = n_start;
        push_words(20480, 256);
        wr_req = 1'b1;
        @(negedge clk);
        check("f_stray_wr_data", 32'(wr_data), 32'd0);
        repeat (3) @(negedge clk);
        wr_req = 1'b0;
        repeat (20) @(negedge clk);
        check("f_no_start", 32'(n_start - s0), 32'd0);
        sd_init_done = 1'b1;
        lat = 0;
        while (wr_start_en !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("f_start_latency", 32'(lat), 32'd2);
        sd_serve(ok);
        check("f_start", 32'(ok), 32'd1);
        check("f_addr", cap_addr, 32'd2000);
        check_cap("f_data", 20480, 256);
        check("f_sec_cnt", sec_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_stream_wr.md
SD_STREAM_WR -- requirements
Module: sd_stream_wr

Interface
REQ-001 Parameter START_ADDR, default 32'd2000: first SD sector address written after reset.
REQ-002 Parameter SEC_WORDS, default 256: 16-bit words per 512-byte sector.
REQ-003 Parameter FIFO_DEPTH, default 512: buffer capacity in words (two sectors).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 sd_init_done  in  1  SD card initialised; no write starts while low.
REQ-007 din_valid  in  1  upstream word valid.
REQ-008 din  in  16  upstream data word.
REQ-009 din_ready  out  1  buffer can accept a word this cycle.
REQ-010 flush  in  1  single-cycle pulse: write out any partial sector, zero-padded.
REQ-011 wr_busy  in  1  SD write controller busy.
REQ-012 wr_req  in  1  SD write controller requests the next data word.
REQ-013 wr_start_en  out  1  single-cycle pulse starting one sector write.
REQ-014 wr_sec_addr  out  32  sector address, stable from wr_start_en until wr_busy falls.
REQ-015 wr_data  out  16  word supplied to the SD write controller.
REQ-016 sec_cnt  out  32  number of sectors completed since reset.
REQ-017 overflow  out  1  sticky: a word was offered while din_ready was low.
REQ-018 done  out  1  single-cycle pulse: flush complete and buffer empty.

Function
REQ-019 Buffer is a FIFO_DEPTH x 16 circular FIFO with an occupancy counter; pointers wrap modulo FIFO_DEPTH.
REQ-020 din_ready = (count != FIFO_DEPTH). A push occurs when din_valid && din_ready.
REQ-021 din_valid && !din_ready drops the word and sets overflow; overflow clears only on reset.
REQ-022 wr_data shows the FIFO head in show-ahead mode. A pop occurs on each wr_req cycle in XFER while the sector word counter is below SEC_WORDS.
REQ-023 Push and pop in the same cycle leave count unchanged; both pointers advance.
REQ-024 FSM states and transitions:
- IDLE -> WAIT_DATA when sd_init_done=1.
- WAIT_DATA -> START when count >= SEC_WORDS, or when flush_pend && count > 0.
- START: wr_start_en=1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY -> XFER on wr_busy=1.
- XFER -> WAIT_DONE after SEC_WORDS wr_req pulses have been served.
- WAIT_DONE -> WAIT_DATA on wr_busy=0; on that edge sec_cnt += 1 and wr_sec_addr += 1.
REQ-025 Sector word counter: 9 bits, cleared in START, incremented per served wr_req.
REQ-026 Partial-sector flush: in XFER with flush_pend and an empty FIFO, wr_data = 16'h0000, no pop occurs, and the word counter still advances.
REQ-027 flush sets flush_pend (a flush arriving in any state is registered). flush_pend clears, and done pulses one cycle, on WAIT_DONE -> WAIT_DATA with count == 0, or in WAIT_DATA when count == 0 with no write pending.
REQ-028 wr_req received outside XFER, or after SEC_WORDS words have been served, is ignored: no pop, and wr_data = 16'h0000.
REQ-029 wr_sec_addr and sec_cnt wrap modulo 2^32.
REQ-030 A sector write never starts while sd_init_done=0; if sd_init_done falls, the current sector completes and the FSM then holds in WAIT_DATA.

Reset
REQ-031 While rst_n=0:
- FSM = IDLE; FIFO empty; pointers and counters = 0.
- wr_sec_addr = START_ADDR; sec_cnt = 0.
- wr_start_en = 0, wr_data = 0, overflow = 0, done = 0, flush_pend = 0; din_ready = 1.
REQ-032 Reset asserted mid-sector discards all buffered data. After release, the next write begins at START_ADDR.

Verification
REQ-033 sd_init_done=1, push 256 words 0..255 -> one wr_start_en pulse with wr_sec_addr=2000; the SD model receives 0..255 in order; sec_cnt=1 and wr_sec_addr=2001 after wr_busy falls.
REQ-034 Push 100 words, pulse flush -> one sector written containing words 0..99 followed by 156 zeros; done pulses once; sec_cnt=1.
REQ-035 Hold wr_busy high (stalled SD model) and push 520 words -> din_ready low at count 512; overflow=1; 8 words dropped; 512 words delivered once the stall releases.
REQ-036 Continuous din_valid while a sector is draining -> simultaneous push/pop keeps count correct; 4 consecutive sectors hold contiguous data at addresses 2000..2003.
REQ-037 Assert rst_n low at word 128 of the XFER phase, then resume -> outputs return to reset values; the next sector is written to 2000; overflow=0.
REQ-038 sd_init_done=0 with 256 words buffered -> no wr_start_en; raising sd_init_done starts the write within 2 cycles.
